// File: rtl/shift_rows_stream.sv
// AES/Rijndael ShiftRows (forward or inverse per block) for Nb = 4/6/8,
// followed by a 2-entry output buffer so IN_READY never depends on OUT_READY.
module shift_rows_stream #(
    parameter  int unsigned NB           = 4,
    localparam int unsigned BLOCK_LENGTH = 32 * NB
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    IN_INV,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    OUT_INV
);

    localparam int unsigned NBYTES = 4 * NB;

    // Buffer occupancy doubles as the FSM state encoding.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    // Row offsets; 256-bit blocks use the wider 0,1,3,4 schedule.
    function automatic int unsigned row_shift(input int unsigned r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    logic [BLOCK_LENGTH-1:0] fwd_c;
    logic [BLOCK_LENGTH-1:0] inv_c;
    logic [BLOCK_LENGTH-1:0] xf_c;

    // Pure byte routing: byte k sits at the MSB end, state is column-major.
    for (genvar gc = 0; gc < NB; gc++) begin : g_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            localparam int unsigned SH  = row_shift(gr);
            localparam int unsigned SF  = (gc + SH) % NB;
            localparam int unsigned SI  = (gc + NB - SH) % NB;
            localparam int unsigned DST = 4 * gc + gr;
            localparam int unsigned BF  = 4 * SF + gr;
            localparam int unsigned BI  = 4 * SI + gr;
            assign fwd_c[BLOCK_LENGTH-1-8*DST -: 8] = IN[BLOCK_LENGTH-1-8*BF -: 8];
            assign inv_c[BLOCK_LENGTH-1-8*DST -: 8] = IN[BLOCK_LENGTH-1-8*BI -: 8];
        end
    end

    assign xf_c = IN_INV ? inv_c : fwd_c;

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic                    wr_ptr_q;
    logic                    wr_ptr_d;
    logic                    rd_ptr_q;
    logic                    rd_ptr_d;
    logic [BLOCK_LENGTH-1:0] data_q [2];
    logic                    inv_q  [2];
    logic                    push_c;
    logic                    pop_c;

    assign IN_READY  = (state_q != ST_FULL) && !RST;
    assign OUT_VALID = (state_q != ST_EMPTY);
    assign OUT       = data_q[rd_ptr_q];
    assign OUT_INV   = inv_q[rd_ptr_q];

    assign push_c = IN_VALID && IN_READY;
    assign pop_c  = OUT_VALID && OUT_READY;

    // Next-state and pointer logic for the 2-entry buffer.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case (state_q)
            ST_EMPTY: begin
                if (push_c) begin
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (push_c && !pop_c) begin
                    state_d = ST_FULL;
                end else if (pop_c && !push_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop_c) begin
                    state_d = ST_HALF;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Reset discards buffered blocks and ignores handshakes in that cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                inv_q[i]  <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_c) begin
                data_q[wr_ptr_q] <= xf_c;
                inv_q[wr_ptr_q]  <= IN_INV;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Scoreboard bench for shift_rows_stream at NB = 4, 6 and 8.
module tb_shift_rows_stream;

    typedef struct {
        logic [255:0] d;
        logic         inv;
    } exp_t;

    localparam logic [127:0] A4  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EA4 = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] IA4 = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [191:0] A6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] EF6 = 192'h00050a0f04090e13080d12170c111603101502071401060b;
    localparam logic [191:0] EI6 = 192'h0015120f04011613080502170c090603100d0a0714110e0b;
    localparam logic [255:0] A8  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] EF8 =
        256'h00050e130409121708_0d161b0c111a1f10151e0314190207181d060b1c010a0f;
    localparam logic [255:0] EI8 =
        256'h001d161304011a1708051e1b0c09021f100d060314110a0718150e0b1c19120f;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
    logic [127:0] in4, out4;
    logic         in_valid6, in_ready6, in_inv6, out_valid6, out_ready6, out_inv6;
    logic [191:0] in6, out6;
    logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
    logic [255:0] in8, out8;

    exp_t q4[$];
    exp_t q6[$];
    exp_t q8[$];
    exp_t e4, e6, e8;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;
    logic         hold_pend = 1'b0;
    logic [127:0] hold_d;
    logic         hold_inv;

    always #5 clk = ~clk;

    shift_rows_stream #(.NB(4)) u4 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid4), .IN_READY(in_ready4), .IN(in4),
        .IN_INV(in_inv4), .OUT_VALID(out_valid4), .OUT_READY(out_ready4), .OUT(out4),
        .OUT_INV(out_inv4)
    );
    shift_rows_stream #(.NB(6)) u6 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid6), .IN_READY(in_ready6), .IN(in6),
        .IN_INV(in_inv6), .OUT_VALID(out_valid6), .OUT_READY(out_ready6), .OUT(out6),
        .OUT_INV(out_inv6)
    );
    shift_rows_stream #(.NB(8)) u8 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8), .IN(in8),
        .IN_INV(in_inv8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .OUT(out8),
        .OUT_INV(out_inv8)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model4(input logic [127:0] d, input logic inv);
        logic [127:0] o;
        int           sc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = d[127-8*(4*sc+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Hold the block on the selected DUT until accepted; record its expectation.
    task automatic send(input int which, input logic [255:0] d, input logic inv,
                        input logic [255:0] exp);
        bit   done = 1'b0;
        int   waited = 0;
        logic rdy;
        case (which)
            4:       begin in4 = d[127:0]; in_inv4 = inv; in_valid4 = 1'b1; end
            6:       begin in6 = d[191:0]; in_inv6 = inv; in_valid6 = 1'b1; end
            default: begin in8 = d;        in_inv8 = inv; in_valid8 = 1'b1; end
        endcase
        while (!done) begin
            @(negedge clk);
            rdy = (which == 4) ? in_ready4 : (which == 6) ? in_ready6 : in_ready8;
            if (rdy && !rst) begin
                case (which)
                    4:       q4.push_back(exp_t'{d: exp, inv: inv});
                    6:       q6.push_back(exp_t'{d: exp, inv: inv});
                    default: q8.push_back(exp_t'{d: exp, inv: inv});
                endcase
                done = 1'b1;
            end
            sync();
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL send_timeout: got no accept on nb=%0d expected accept", which);
                    done = 1'b1;
                end
            end
        end
        case (which)
            4:       in_valid4 = 1'b0;
            6:       in_valid6 = 1'b0;
            default: in_valid8 = 1'b0;
        endcase
    endtask

    task automatic drain();
        int t = 0;
        while ((q4.size() + q6.size() + q8.size()) != 0 && t < 500) begin
            sync();
            t++;
        end
        check("drain_left", 256'(q4.size() + q6.size() + q8.size()), 256'(0));
    endtask

    // Monitors: pop the scoreboard whenever a DUT output is taken.
    always @(negedge clk) begin
        if (hold_pend && !rst) begin
            check("u4_hold_valid", 256'(out_valid4), 256'(1'b1));
            check("u4_hold_data", 256'(out4), 256'(hold_d));
            check("u4_hold_inv", 256'(out_inv4), 256'(hold_inv));
        end
        hold_pend = out_valid4 && !out_ready4 && !rst;
        hold_d    = out4;
        hold_inv  = out_inv4;
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL u4_unexpected: got %h expected no block", out4);
            end else begin
                e4 = q4.pop_front();
                check("u4_data", 256'(out4), e4.d);
                check("u4_inv", 256'(out_inv4), 256'(e4.inv));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid6 && out_ready6) begin
            if (q6.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL u6_unexpected: got %h expected no block", out6);
            end else begin
                e6 = q6.pop_front();
                check("u6_data", 256'(out6), e6.d);
                check("u6_inv", 256'(out_inv6), 256'(e6.inv));
            end
        end
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL u8_unexpected: got %h expected no block", out8);
            end else begin
                e8 = q8.pop_front();
                check("u8_data", out8, e8.d);
                check("u8_inv", 256'(out_inv8), 256'(e8.inv));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready4 = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [127:0] d;
        logic         inv;
        rst = 1'b1;
        in_valid4 = 1'b0; in_valid6 = 1'b0; in_valid8 = 1'b0;
        in_inv4 = 1'b0;   in_inv6 = 1'b0;   in_inv8 = 1'b0;
        in4 = '0;         in6 = '0;         in8 = '0;
        out_ready4 = 1'b1; out_ready6 = 1'b1; out_ready8 = 1'b1;
        sync();
        sync();
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready4), 256'(1'b0));
        check("rst_out_valid", 256'(out_valid4), 256'(1'b0));
        check("rst_out", 256'(out4), 256'(0));
        check("rst_out_inv", 256'(out_inv4), 256'(1'b0));
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 256'(in_ready4), 256'(1'b1));
        sync();

        // Single forward block: visible one edge after accept, for one cycle.
        send(4, 256'(A4), 1'b0, 256'(EA4));
        @(negedge clk);
        check("lat_valid", 256'(out_valid4), 256'(1'b1));
        sync();
        @(negedge clk);
        check("lat_gone", 256'(out_valid4), 256'(1'b0));
        sync();

        send(4, 256'(A4), 1'b1, 256'(IA4));
        drain();
        send(4, 256'(A4), 1'b0, 256'(EA4));
        send(4, 256'(EA4), 1'b1, 256'(A4));
        drain();

        send(6, 256'(A6), 1'b0, 256'(EF6));
        send(6, 256'(A6), 1'b1, 256'(EI6));
        send(8, A8, 1'b0, EF8);
        send(8, A8, 1'b1, EI8);
        send(8, EF8, 1'b1, A8);
        drain();

        // Backpressure: two blocks fill the buffer, the third is held.
        out_ready4 = 1'b0;
        send(4, 256'(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF), 1'b0,
             256'(128'hA0A5AAAFA4A9AEA3A8ADA2A7ACA1A6AB));
        send(4, 256'(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF), 1'b1,
             256'(128'hB0BDBAB7B4B1BEBBB8B5B2BFBCB9B6B3));
        @(negedge clk);
        check("bp_full_ready", 256'(in_ready4), 256'(1'b0));
        sync();
        fork
            send(4, 256'(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF), 1'b0,
                 256'(128'hC0C5CACFC4C9CEC3C8CDC2C7CCC1C6CB));
        join_none
        sync();
        sync();
        @(negedge clk);
        check("bp_held_ready", 256'(in_ready4), 256'(1'b0));
        check("bp_held_valid", 256'(out_valid4), 256'(1'b1));
        sync();
        out_ready4 = 1'b1;
        wait fork;
        drain();

        // Random streaming with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                sync();
            end
            send(4, 256'(d), inv, 256'(model4(d, inv)));
        end
        rand_rdy = 1'b0;
        sync();
        out_ready4 = 1'b1;
        drain();

        // Reset with the buffer full; handshakes during reset are ignored.
        out_ready4 = 1'b0;
        send(4, 256'(A4), 1'b1, 256'(IA4));
        send(4, 256'(EA4), 1'b0, 256'(128'h0));
        @(negedge clk);
        check("full_ready", 256'(in_ready4), 256'(1'b0));
        sync();
        rst = 1'b1;
        in4 = 128'hDEADBEEF_00000000_11111111_22222222;
        in_valid4 = 1'b1;
        out_ready4 = 1'b1;
        @(negedge clk);
        check("rst_hi_ready", 256'(in_ready4), 256'(1'b0));
        sync();
        @(negedge clk);
        check("mid_rst_valid", 256'(out_valid4), 256'(1'b0));
        check("mid_rst_out", 256'(out4), 256'(0));
        check("mid_rst_inv", 256'(out_inv4), 256'(1'b0));
        q4.delete();
        sync();
        rst = 1'b0;
        in_valid4 = 1'b0;
        @(negedge clk);
        check("rel_ready", 256'(in_ready4), 256'(1'b1));
        check("rel_valid", 256'(out_valid4), 256'(1'b0));
        sync();
        send(4, 256'(A4), 1'b0, 256'(EA4));
        @(negedge clk);
        check("fresh_valid", 256'(out_valid4), 256'(1'b1));
        sync();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Parametrised, flow-controlled AES/Rijndael ShiftRows stage for 128/192/256-bit blocks (Nb = 4/6/8 columns). It supports forward and inverse ShiftRows per transaction, selected by a tag bit carried with the data. Transformed blocks go into a 2-entry output buffer, so upstream ready never depends combinationally on downstream ready. The block sits between SubBytes and MixColumns in the round datapath, and between InvShiftRows' neighbours in the decrypt path.

## Interface
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error
- BLOCK_LENGTH, 32*NB, derived localparam (not overridable); block width in bits
- CLK  in  1  rising-edge clock; the only clock
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  input block valid
- IN_READY  out  1  block can accept input this cycle
- IN  in  BLOCK_LENGTH  input state
- IN_INV  in  1  0 = forward ShiftRows, 1 = inverse; sampled with IN
- OUT_VALID  out  1  output block valid
- OUT_READY  in  1  downstream accepts output
- OUT  out  BLOCK_LENGTH  transformed state (head of buffer)
- OUT_INV  out  1  IN_INV tag travelling with OUT

## Operation
- Byte order: byte k at IN[BLOCK_LENGTH-1-8k -: 8]; state is column-major, s[r][c] = byte 4c+r; OUT uses the same packing.
- Shift offsets per row r=0..3: NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
- Forward: s'[r][c] = s[r][(c + sh(r)) mod NB].
- Inverse: s'[r][c] = s[r][(c - sh(r)) mod NB].
- Transform is combinational on IN; the result is written into the buffer on accept.
- Accept = IN_VALID & IN_READY: write {transformed IN, IN_INV} to the tail entry.
- Pop = OUT_VALID & OUT_READY: advance the head.
- Buffer: 2 entries, write/read pointers (1 bit each), occupancy count 0..2.
  - States: EMPTY (0), HALF (1), FULL (2).
  - EMPTY --push--> HALF.
  - HALF --push only--> FULL.
  - HALF --pop only--> EMPTY.
  - HALF --push & pop--> HALF.
  - FULL --pop--> HALF. Push is impossible in FULL.
- IN_READY = (count != 2) & !RST. OUT_VALID = (count != 0).
- There is no bypass path: a block accepted in EMPTY is not visible at OUT in the same cycle.
- Order is strict FIFO; the mode tag never reorders blocks.
- OUT/OUT_INV hold stable while OUT_VALID=1 and OUT_READY=0.
- IN and IN_INV are don't-care when IN_VALID=0 or IN_READY=0.

## Timing
- Reset (RST=1 at a rising edge):
  - count, pointers, OUT_VALID, OUT, OUT_INV all go to 0.
  - Buffer contents are cleared to 0.
  - IN_READY is 0 while RST is high, and 1 in the first cycle after RST falls.
- Latency: block accepted at edge N gives OUT_VALID=1 after edge N, so it is poppable at edge N+1.
- Throughput: 1 block/cycle with OUT_READY held high.
- Simultaneous push and pop in HALF: both happen; count is unchanged; the new block becomes head on the following cycle.
- Pointers wrap modulo 2.
- Reset mid-operation: all buffered blocks are discarded. Handshakes in the reset cycle are ignored on both sides. No block emerges after reset unless it is re-sent.
- IN_READY is a function of registered count and RST only. There is no combinational path from OUT_READY or IN_VALID to IN_READY.

## Test plan
- NB=4, forward, IN=000102…0f, OUT_READY=1 -> one cycle later OUT=00050a0f04090e03080d02070c01060b, OUT_INV=0, OUT_VALID for exactly 1 cycle.
- NB=4, inverse, IN=000102…0f -> OUT=000d0a0704010e0b0805020f0c090603, OUT_INV=1. Forward then inverse back-to-back returns the original block.
- NB=8, forward, IN=000102…1f -> OUT column 0 = 00050e13, column 7 = 1c010a0f. NB=6 gives column 0 = 00050a0f, column 5 = 1401060b.
- Backpressure, NB=4: push A, B with OUT_READY=0 -> IN_READY=0 after the second accept; C is held. Then raise OUT_READY -> A, B, C emerge in order, one per cycle, tags preserved, no loss or duplication.
- Streaming with random IN_VALID/OUT_READY, 1000 blocks, random mode -> scoreboard matches a reference model and count never exceeds 2.
- Assert RST with the buffer FULL -> next cycle OUT_VALID=0 and OUT=0. IN_READY=1 the cycle after RST falls, and a fresh block passes with 1-cycle latency.
